// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl (+ FourBitRippleCarryAdder)
// Brief    : Wide add/subtract computed one nibble per clock on a shared
//            4-bit ripple-carry adder, with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================

module FourBitRippleCarryAdder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c4_o
);
  always_comb begin
    logic w_c;
    w_c = c_i;
    s_o = 4'h0;
    for (int k = 0; k < 4; k++) begin
      s_o[k] = a_i[k] ^ b_i[k] ^ w_c;
      w_c    = (a_i[k] & b_i[k]) | (w_c & (a_i[k] ^ b_i[k]));
    end
    c4_o = w_c;
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 sub_i,
  input  logic [4*NIBBLES-1:0] a_i,
  input  logic [4*NIBBLES-1:0] b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*NIBBLES-1:0] result_o,
  output logic                 cout_o,
  output logic                 ovf_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    w_nib_a, w_nib_b, w_sum;
  logic          w_c4;

  assign w_nib_a = opa_q[{idx_q, 2'b00} +: 4];
  assign w_nib_b = opb_q[{idx_q, 2'b00} +: 4];

  FourBitRippleCarryAdder u_adder (
    .a_i  (w_nib_a),
    .b_i  (w_nib_b),
    .c_i  (carry_q),
    .s_o  (w_sum),
    .c4_o (w_c4)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          opa_d    = a_i;
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          opb_d    = sub_i ? ~b_i : b_i;
          carry_d  = sub_i;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = w_sum;
        carry_d = w_c4;
        if (idx_q == C_LAST_IDX) begin
          cout_d  = w_c4;
          ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (w_sum[3] != opa_q[W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign busy_o   = (state_q == S_RUN) || (state_q == S_DONE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Directed self-checking bench for nibble_serial_adder_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .sub_i    (sub),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .cout_o   (cout),
    .ovf_o    (ovf)
  );

  // Stimulus driver: launches one op, reports latency (edges incl. accepting
  // edge), busy-high cycle count and the outputs sampled in the done cycle.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        output int lat, output int bcnt,
                        output logic [15:0] res, output logic co, output logic ov);
    lat = 0; bcnt = 0; res = 'x; co = 1'bx; ov = 1'bx;
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; a = ~av; b = ~bv; sub = ~sv;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = i + 1; res = result; co = cout; ov = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== 16'h0)   begin bad++; $display("FAIL reset_result got=%h exp=0000", result); end
    total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {cout, ovf}); end
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int lat, bcnt; logic [15:0] r; logic co, ov;
    run_op(16'h1234, 16'h0FFF, 1'b0, lat, bcnt, r, co, ov);
    total++; if (lat !== 5)        begin bad++; $display("FAIL add_latency got=%0d exp=5", lat); end
    total++; if (bcnt !== 5)       begin bad++; $display("FAIL add_busy_cycles got=%0d exp=5", bcnt); end
    total++; if (r !== 16'h2233)   begin bad++; $display("FAIL add_result got=%h exp=2233", r); end
    total++; if ({co, ov} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b exp=00", {co, ov}); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL add_idle got=%b exp=00", {busy, done}); end
    repeat (3) @(negedge clk);
    total++; if (result !== 16'h2233) begin bad++; $display("FAIL idle_hold got=%h exp=2233", result); end
  endtask

  task automatic test_arith_vectors();
    logic [15:0] va [4] = '{16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
    logic [15:0] vb [4] = '{16'h0001, 16'h0007, 16'h0001, 16'h0001};
    logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] er [4] = '{16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000};
    logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 4; t++) begin
      int lat, bcnt; logic [15:0] r; logic co, ov;
      run_op(va[t], vb[t], vs[t], lat, bcnt, r, co, ov);
      total++; if (lat !== 5)    begin bad++; $display("FAIL vec%0d_latency got=%0d exp=5", t, lat); end
      total++; if (r !== er[t])  begin bad++; $display("FAIL vec%0d_result got=%h exp=%h", t, r, er[t]); end
      total++; if (co !== ec[t]) begin bad++; $display("FAIL vec%0d_cout got=%b exp=%b", t, co, ec[t]); end
      total++; if (ov !== eo[t]) begin bad++; $display("FAIL vec%0d_ovf got=%b exp=%b", t, ov, eo[t]); end
    end
  endtask

  task automatic test_back_to_back();
    int dcnt = 0;
    int lat2 = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin a = 16'hAAAA; b = 16'h1111; sub = 1'b1; end
      if (done) dcnt++;
      if (i == 4) begin
        total++; if (done !== 1'b1)     begin bad++; $display("FAIL b2b_done_cycle got=%b exp=1", done); end
        total++; if (result !== 16'h3333) begin bad++; $display("FAIL b2b_result got=%h exp=3333", result); end
      end
      if (i == 5) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b exp=0", busy); end
      end
      if (i == 6) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b exp=1", busy); end
        total++; if (dcnt !== 1)    begin bad++; $display("FAIL b2b_one_pulse got=%0d exp=1", dcnt); end
        start = 1'b0;
      end
      if (i > 6 && done) begin
        lat2 = i - 5;
        total++; if (result !== 16'h9999) begin bad++; $display("FAIL b2b_second_result got=%h exp=9999", result); end
        total++; if ({cout, ovf} !== 2'b10) begin bad++; $display("FAIL b2b_second_flags got=%b exp=10", {cout, ovf}); end
        break;
      end
    end
    total++; if (lat2 !== 5) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=5", lat2); end
  endtask

  task automatic test_mid_reset();
    int dcnt = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(negedge clk);                 // first RUN cycle
    start = 1'b0;
    @(negedge clk);                 // second RUN cycle
    total++; if (result !== 16'h0003) begin bad++; $display("FAIL rst_partial got=%h exp=0003", result); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_ctrl got=%b exp=00", {busy, done}); end
    total++; if (result !== 16'h0)    begin bad++; $display("FAIL rst_result got=%h exp=0000", result); end
    total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {cout, ovf}); end
    start = 1'b1;                   // rst must win over start
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_priority got=%b exp=0", busy); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", dcnt); end
  endtask

  task automatic test_after_reset();
    int lat, bcnt; logic [15:0] r; logic co, ov;
    run_op(16'h4321, 16'h1234, 1'b1, lat, bcnt, r, co, ov);
    total++; if (lat !== 5)          begin bad++; $display("FAIL fresh_latency got=%0d exp=5", lat); end
    total++; if (r !== 16'h30ED)     begin bad++; $display("FAIL fresh_result got=%h exp=30ed", r); end
    total++; if ({co, ov} !== 2'b10) begin bad++; $display("FAIL fresh_flags got=%b exp=10", {co, ov}); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_arith_vectors();
    test_back_to_back();
    test_mid_reset();
    test_after_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
